snake_head_ctrl: RTL and testbench

- Consumer of the 2-bit `direction` code from the keypad direction latch.
- Advances the snake head one grid cell per game tick and suppresses 180° reversals.
- Detects wall collision and exposes head coordinates plus a one-cycle move strobe to the body/render logic.

---
 rtl/snake_head_ctrl_pkg.sv | 29 ++
 rtl/snake_head_ctrl_tick_gen.sv | 47 ++++
 rtl/snake_head_ctrl.sv | 166 ++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_head_ctrl_pkg.sv
// Shared direction/state encodings and the reversal helper for the snake head controller.
package snake_head_ctrl_pkg;

  typedef enum logic [1:0] {
    TOP_DIR   = 2'b00,
    DOWN_DIR  = 2'b01,
    LEFT_DIR  = 2'b10,
    RIGHT_DIR = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_e;

  function automatic dir_e opposite_dir(input dir_e d);
    dir_e r;
    case (d)
      TOP_DIR:   r = DOWN_DIR;
      DOWN_DIR:  r = TOP_DIR;
      LEFT_DIR:  r = RIGHT_DIR;
      RIGHT_DIR: r = LEFT_DIR;
      default:   r = TOP_DIR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_head_ctrl_tick_gen.sv
// Game tick generator: counts enabled cycles and pulses tick on the last cycle of each period.
module game_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: clear wins, otherwise advance (and wrap) only while running
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_ZERO;
    end else if (run) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run & ~clear & (cnt_q == CNT_MAX);

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: one cell per game tick, 180-degree reversal suppression, wall detection.
// Define SNAKE_WRAP_EN to make grid edges wrap around instead of killing the snake.
module snake_head_ctrl
  import snake_head_ctrl_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int TICK_DIV = 5000000,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [1:0]                direction,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [1:0]                heading,
  output logic                      move_strobe,
  output logic                      wall_hit,
  output logic [1:0]                state_o
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;

  localparam logic [XE-1:0] X_MAX   = XE'(GRID_W - 1);
  localparam logic [YE-1:0] Y_MAX   = YE'(GRID_H - 1);
  localparam logic [XE-1:0] X_ONE   = XE'(1);
  localparam logic [YE-1:0] Y_ONE   = YE'(1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);

  state_e          state_q, state_d;
  dir_e            heading_q, heading_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            strobe_q, strobe_d;
  logic            wall_q, wall_d;

  dir_e            dir_s;
  dir_e            new_hd_s;
  logic [XE-1:0]   nx_s;
  logic [YE-1:0]   ny_s;
  logic            hit_s;
  logic            tick_s;
  logic            run_s;
  logic            clear_s;

  assign run_s   = (state_q == RUN) & enable;
  assign clear_s = restart | (state_q != RUN);

  game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run_s),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // candidate next position, one bit wider so a step off either edge shows up as > MAX
  always_comb begin
    dir_s    = dir_e'(direction);
    new_hd_s = (dir_s == opposite_dir(heading_q)) ? heading_q : dir_s;
    nx_s     = {1'b0, x_q};
    ny_s     = {1'b0, y_q};
    case (new_hd_s)
      TOP_DIR:   ny_s = {1'b0, y_q} - Y_ONE;
      DOWN_DIR:  ny_s = {1'b0, y_q} + Y_ONE;
      LEFT_DIR:  nx_s = {1'b0, x_q} - X_ONE;
      RIGHT_DIR: nx_s = {1'b0, x_q} + X_ONE;
      default:   nx_s = {1'b0, x_q};
    endcase
    hit_s = (nx_s > X_MAX) | (ny_s > Y_MAX);
`ifdef SNAKE_WRAP_EN
    if (hit_s) begin
      case (new_hd_s)
        TOP_DIR:   ny_s = Y_MAX;
        DOWN_DIR:  ny_s = {YE{1'b0}};
        LEFT_DIR:  nx_s = X_MAX;
        RIGHT_DIR: nx_s = {XE{1'b0}};
        default:   nx_s = {1'b0, x_q};
      endcase
    end else begin
      nx_s = nx_s;
    end
    hit_s = 1'b0;
`endif
  end

  // next-state and next-output logic; restart outranks any tick in the same cycle
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    x_d       = x_q;
    y_d       = y_q;
    strobe_d  = 1'b0;
    wall_d    = wall_q;
    if (restart) begin
      state_d   = IDLE;
      heading_d = TOP_DIR;
      x_d       = X_START;
      y_d       = Y_START;
      wall_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = enable ? RUN : IDLE;
        end
        RUN: begin
          if (tick_s) begin
            heading_d = new_hd_s;
            if (hit_s) begin
              state_d = DEAD;
              wall_d  = 1'b1;
            end else begin
              x_d      = nx_s[XW-1:0];
              y_d      = ny_s[YW-1:0];
              strobe_d = 1'b1;
            end
          end else begin
            state_d = RUN;
          end
        end
        DEAD: begin
          wall_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      heading_q <= TOP_DIR;
      x_q       <= X_START;
      y_q       <= Y_START;
      strobe_q  <= 1'b0;
      wall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      x_q       <= x_d;
      y_q       <= y_d;
      strobe_q  <= strobe_d;
      wall_q    <= wall_d;
    end
  end

  assign head_x      = x_q;
  assign head_y      = y_q;
  assign heading     = heading_q;
  assign move_strobe = strobe_q;
  assign wall_hit    = wall_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Self-checking bench for snake_head_ctrl against a cell-level game model (TICK_DIV shortened to 4).
module tb_snake_head_ctrl;

  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int TICK_DIV = 4;
  localparam int START_X  = 16;
  localparam int START_Y  = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       restart;
  logic [1:0] direction;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] heading;
  logic       move_strobe;
  logic       wall_hit;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;

  snake_head_ctrl #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .TICK_DIV (TICK_DIV),
    .START_X  (START_X),
    .START_Y  (START_Y)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .restart     (restart),
    .direction   (direction),
    .head_x      (head_x),
    .head_y      (head_y),
    .heading     (heading),
    .move_strobe (move_strobe),
    .wall_hit    (wall_hit),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // model: game state 0 idle / 1 run / 2 dead, head cell, heading, and enabled cycles left to the next tick
  int m_state, m_x, m_y, m_hd, m_left;
  bit m_strobe, m_wall;

  logic [15:0] dut_v;
  assign dut_v = {state_o, head_x, head_y, heading, move_strobe, wall_hit};

  function automatic logic [15:0] exp_vec();
    return {2'(m_state), 5'(m_x), 5'(m_y), 2'(m_hd), m_strobe, m_wall};
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = START_X; m_y = START_Y; m_hd = 0;
    m_left = TICK_DIV; m_strobe = 1'b0; m_wall = 1'b0;
  endtask

  task automatic apply_move(input int d);
    int nh, tx, ty;
    nh = ((d ^ 1) == m_hd) ? m_hd : d;
    tx = m_x; ty = m_y;
    case (nh)
      0: ty = ty - 1;
      1: ty = ty + 1;
      2: tx = tx - 1;
      default: tx = tx + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    tx = (tx + GRID_W) % GRID_W;
    ty = (ty + GRID_H) % GRID_H;
`endif
    m_hd = nh;
    if (tx < 0 || tx >= GRID_W || ty < 0 || ty >= GRID_H) begin
      m_state = 2; m_wall = 1'b1;
    end else begin
      m_x = tx; m_y = ty; m_strobe = 1'b1;
    end
  endtask

  // drive one cycle of inputs, advance the model, and land 1 time unit after the clock edge
  task automatic step(input bit en, input bit rs, input logic [1:0] dir);
    enable = en; restart = rs; direction = dir;
    m_strobe = 1'b0;
    if (rs) begin
      model_reset();
    end else if (m_state == 0) begin
      if (en) begin m_state = 1; m_left = TICK_DIV; end
    end else if (m_state == 1 && en) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left = TICK_DIV;
        apply_move(int'(dir));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; restart = 1'b0; direction = 2'b00;
    #2;
    checks++;
    if ({head_x, head_y, heading, move_strobe, wall_hit, state_o} !== {5'd16, 5'd12, 2'd0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d hd=%0d stb=%b wall=%b st=%0d, want 16 12 0 0 0 0",
               head_x, head_y, heading, move_strobe, wall_hit, state_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 2'b00);
    checks++;
    if (dut_v !== exp_vec()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", dut_v, exp_vec());
    end
  endtask

  task automatic test_first_move();
    int n, gap;
    n = 0;
    while (!move_strobe && n < 20) begin
      step(1'b1, 1'b0, 2'b00);
      n++;
      checks++;
      if (dut_v !== exp_vec()) begin errors++; $display("FAIL first_move: got %h want %h", dut_v, exp_vec()); end
    end
    checks++;
    if (n !== TICK_DIV + 1) begin errors++; $display("FAIL first_latency: got %0d cycles want %0d", n, TICK_DIV + 1); end
    checks++;
    if ({head_x, head_y} !== {5'd16, 5'd11}) begin errors++; $display("FAIL first_pos: got (%0d,%0d) want (16,11)", head_x, head_y); end
    gap = 0;
    do begin
      step(1'b1, 1'b0, 2'b00);
      gap++;
    end while (!move_strobe && gap < 20);
    checks++;
    if (gap !== TICK_DIV) begin errors++; $display("FAIL strobe_spacing: got %0d want %0d", gap, TICK_DIV); end
  endtask

  task automatic test_reversal();
    int n;
    n = 0;
    do begin step(1'b1, 1'b0, 2'b01); n++; end while (!move_strobe && n < 20);
    checks++;
    if ({head_x, head_y, heading} !== {5'd16, 5'd9, 2'd0}) begin
      errors++; $display("FAIL reversal: got (%0d,%0d) hd=%0d want (16,9) hd=0", head_x, head_y, heading);
    end
    n = 0;
    do begin step(1'b1, 1'b0, 2'b10); n++; end while (!move_strobe && n < 20);
    checks++;
    if ({head_x, head_y, heading} !== {5'd15, 5'd9, 2'd2}) begin
      errors++; $display("FAIL turn_left: got (%0d,%0d) hd=%0d want (15,9) hd=2", head_x, head_y, heading);
    end
    checks++;
    if (dut_v !== exp_vec()) begin errors++; $display("FAIL turn_model: got %h want %h", dut_v, exp_vec()); end
  endtask

  task automatic test_pause();
    int n;
    step(1'b0, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 2'(i));
      checks++;
      if (move_strobe !== 1'b0 || dut_v !== exp_vec()) begin
        errors++; $display("FAIL pause: got %h want %h", dut_v, exp_vec());
      end
    end
    n = 0;
    do begin step(1'b1, 1'b0, 2'b10); n++; end while (!move_strobe && n < 20);
    checks++;
    if (n !== TICK_DIV - 2) begin errors++; $display("FAIL pause_resume: got %0d cycles want %0d", n, TICK_DIV - 2); end
    checks++;
    if ({head_x, head_y, heading} !== {5'd15, 5'd12, 2'd2}) begin
      errors++; $display("FAIL pause_move: got (%0d,%0d) hd=%0d want (15,12) hd=2", head_x, head_y, heading);
    end
  endtask

  task automatic test_wall();
    int guard;
    step(1'b0, 1'b1, 2'b00);
    guard = 0;
    while (m_x != 0 && guard < 400) begin
      step(1'b1, 1'b0, 2'b10); guard++;
      checks++;
      if (dut_v !== exp_vec()) begin errors++; $display("FAIL wall_left: got %h want %h", dut_v, exp_vec()); end
    end
    while (m_y != 5 && guard < 400) begin
      step(1'b1, 1'b0, 2'b00); guard++;
      checks++;
      if (dut_v !== exp_vec()) begin errors++; $display("FAIL wall_up: got %h want %h", dut_v, exp_vec()); end
    end
    do begin step(1'b1, 1'b0, 2'b10); guard++; end while (!m_strobe && m_state != 2 && guard < 400);
    checks++;
    if (guard >= 400) begin errors++; $display("FAIL wall_timeout: got %0d steps want < 400", guard); end
`ifdef SNAKE_WRAP_EN
    checks++;
    if ({head_x, head_y, move_strobe, state_o} !== {5'd31, 5'd5, 1'b1, 2'd1}) begin
      errors++; $display("FAIL wrap_left: got (%0d,%0d) stb=%b st=%0d want (31,5) 1 1", head_x, head_y, move_strobe, state_o);
    end
`else
    checks++;
    if ({head_x, head_y, heading, move_strobe, wall_hit, state_o} !== {5'd0, 5'd5, 2'd2, 1'b0, 1'b1, 2'd2}) begin
      errors++; $display("FAIL wall_hit: got (%0d,%0d) hd=%0d stb=%b wall=%b st=%0d want (0,5) 2 0 1 2",
                         head_x, head_y, heading, move_strobe, wall_hit, state_o);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)));
      checks++;
      if (dut_v !== exp_vec()) begin errors++; $display("FAIL dead_frozen: got %h want %h", dut_v, exp_vec()); end
    end
`endif
    step(1'b1, 1'b1, 2'b11);
    checks++;
    if ({head_x, head_y, heading, wall_hit, state_o} !== {5'd16, 5'd12, 2'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL wall_restart: got (%0d,%0d) hd=%0d wall=%b st=%0d want (16,12) 0 0 0",
                         head_x, head_y, heading, wall_hit, state_o);
    end
  endtask

  task automatic test_bottom_edge();
    int guard;
    step(1'b0, 1'b1, 2'b00);
    guard = 0;
    while (m_x != 5 && guard < 400) begin step(1'b1, 1'b0, 2'b10); guard++; end
    while (m_y != 23 && guard < 400) begin step(1'b1, 1'b0, 2'b01); guard++; end
    do begin step(1'b1, 1'b0, 2'b01); guard++; end while (!m_strobe && m_state != 2 && guard < 400);
    checks++;
    if (dut_v !== exp_vec()) begin errors++; $display("FAIL bottom_model: got %h want %h", dut_v, exp_vec()); end
`ifdef SNAKE_WRAP_EN
    checks++;
    if ({head_x, head_y, move_strobe} !== {5'd5, 5'd0, 1'b1}) begin
      errors++; $display("FAIL wrap_down: got (%0d,%0d) stb=%b want (5,0) 1", head_x, head_y, move_strobe);
    end
`else
    checks++;
    if ({head_x, head_y, wall_hit, state_o} !== {5'd5, 5'd23, 1'b1, 2'd2}) begin
      errors++; $display("FAIL wall_down: got (%0d,%0d) wall=%b st=%0d want (5,23) 1 2", head_x, head_y, wall_hit, state_o);
    end
`endif
  endtask

  task automatic test_restart_tick();
    int guard;
    step(1'b0, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b10);
    guard = 0;
    while (!(m_state == 1 && m_left == 1) && guard < 20) begin step(1'b1, 1'b0, 2'b10); guard++; end
    step(1'b1, 1'b1, 2'b10);
    checks++;
    if ({head_x, head_y, heading, move_strobe, state_o} !== {5'd16, 5'd12, 2'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL restart_tick: got (%0d,%0d) hd=%0d stb=%b st=%0d want (16,12) 0 0 0",
                         head_x, head_y, heading, move_strobe, state_o);
    end
  endtask

  task automatic test_async_rst();
    int guard;
    step(1'b1, 1'b0, 2'b11);
    guard = 0;
    while (!m_strobe && guard < 20) begin step(1'b1, 1'b0, 2'b11); guard++; end
    while (!(m_state == 1 && m_left == 1) && guard < 40) begin step(1'b1, 1'b0, 2'b11); guard++; end
    checks++;
    if (head_x !== 5'd17) begin errors++; $display("FAIL pre_rst_pos: got x=%0d want 17", head_x); end
    enable = 1'b1; restart = 1'b0; direction = 2'b11;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({head_x, head_y, heading, move_strobe, state_o} !== {5'd16, 5'd12, 2'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL async_rst: got (%0d,%0d) hd=%0d stb=%b st=%0d want (16,12) 0 0 0",
                         head_x, head_y, heading, move_strobe, state_o);
    end
    @(posedge clk); #1;
    checks++;
    if (move_strobe !== 1'b0 || head_x !== 5'd16) begin
      errors++; $display("FAIL rst_no_strobe: got stb=%b x=%0d want 0 16", move_strobe, head_x);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int dead_cnt;
    bit en, rs;
    dead_cnt = 0;
    step(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 299) == 0) || (dead_cnt > 4);
      dead_cnt = (m_state == 2) ? dead_cnt + 1 : 0;
      step(en, rs, 2'($urandom_range(0, 3)));
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", i, dut_v, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_reversal();
    test_pause();
    test_wall();
    test_bottom_edge();
    test_restart_tick();
    test_async_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
